downsampler_rate_ctrl: RTL and testbench
========================================

DOWNSAMPLER_RATE_CTRL -- requirements
Module: downsampler_rate_ctrl

Interface
REQ-001 Parameter: RESET_CYCLES, default 4; number of aclk cycles core_aresetn is held low per apply, range 1..255.
REQ-002 aclk  input  1  single clock, all logic rising-edge.
REQ-003 aresetn  input  1  reset, synchronous and active-low.
REQ-004 cfg_ratio  input  32  requested decimation ratio, ufix_32_31.
REQ-005 cfg_valid  input  1  request valid.
REQ-006 cfg_ready  output  1  controller can accept a request.
REQ-007 cfg_error  output  1  last request rejected (sticky until next accepted request).
REQ-008 freqRatio  output  32  ratio applied to the downsampler core, ufix_32_31.
REQ-009 freqRatioInv  output  32  1/freqRatio applied to the core, ufix_32_22.
REQ-010 core_aresetn  output  1  synchronous active-low reset driven to the downsampler core.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states: HOLD, IDLE, CHECK, DIVIDE, APPLY.
REQ-013 Handshake: request accepted on a cycle with cfg_valid && cfg_ready; cfg_ratio captured on that cycle; cfg_ready = 1 only in IDLE.
REQ-014 IDLE -> CHECK on accept; cfg_error cleared on accept.
REQ-015 CHECK (1 cycle): ratio valid iff 0x00200000 < cfg_ratio <= 0x80000000; valid -> DIVIDE; invalid -> IDLE with cfg_error = 1, freqRatio/freqRatioInv/core_aresetn unchanged.
REQ-016 DIVIDE: unsigned restoring division, quotient = floor(2^53 / ratio), exactly 32 cycles, one quotient bit per cycle MSB first; remainder width 33 bits; quotient always fits 32 bits for valid ratios.
REQ-017 DIVIDE -> APPLY: on the APPLY entry edge, freqRatio <= captured ratio, freqRatioInv <= quotient, core_aresetn <= 0, both outputs updated on the same edge.
REQ-018 APPLY: core_aresetn held 0 for exactly RESET_CYCLES cycles, then -> IDLE with core_aresetn = 1.
REQ-019 Accepted request to first IDLE cycle with cfg_ready = 1: 1 + 1 + 32 + RESET_CYCLES cycles (38 for default).
REQ-020 freqRatio/freqRatioInv never change except on the APPLY entry edge; they are stable whenever core_aresetn = 1.
REQ-021 cfg_valid while busy: ignored and not queued; the requester holds it until cfg_ready.
REQ-022 Same ratio as current: processed in full (divide and core reset), no short-cut.

Reset
REQ-023 While aresetn = 0: state HOLD, counter = 0, freqRatio = 0x80000000, freqRatioInv = 0x00400000, core_aresetn = 0, cfg_ready = 0, cfg_error = 0, busy = 1.
REQ-024 After aresetn rises: stay in HOLD for RESET_CYCLES cycles with core_aresetn = 0, then IDLE with core_aresetn = 1.
REQ-025 aresetn low mid-DIVIDE or mid-APPLY: the in-flight request is discarded and the default values of REQ-023 are restored.

Structure
REQ-026 Shared package downsampler_pkg: ONE_VALUE 0x80000000, INV_ONE 0x00400000, MIN_RATIO_EXCL 0x00200000, DIV_DIVIDEND_EXP 53, and the FSM state enum.
REQ-027 Sub-module ratio_inv_divider: start/done, 32-cycle iterative divider; FSM, handshake and reset sequencing live in the top module.

Verification
REQ-028 Post-reset: aresetn low 3 cycles then high -> core_aresetn low for exactly 4 more cycles, freqRatio = 0x80000000, freqRatioInv = 0x00400000, cfg_ready rises.
REQ-029 cfg_ratio 0x40000000 -> after 34 cycles freqRatioInv = 0x00800000, freqRatio = 0x40000000, core_aresetn low 4 cycles, cfg_ready back at cycle 38.
REQ-030 cfg_ratio 0x2AAAAAAB -> freqRatioInv = 0x00BFFFFF; cfg_ratio 0x80000000 -> 0x00400000.
REQ-031 cfg_ratio 0x00200000 and 0x80000001 -> cfg_error = 1 after CHECK, outputs unchanged, core_aresetn stays 1; next valid request clears cfg_error.
REQ-032 cfg_valid held during busy with a second ratio -> accepted only on the first IDLE cycle; outputs never glitch while core_aresetn = 1.
REQ-033 aresetn pulsed low at DIVIDE cycle 10 -> outputs return to 0x80000000/0x00400000 and the HOLD sequence restarts; the aborted ratio is never applied.

Source files
------------

// File: rtl/downsampler_pkg.sv
// Shared constants, FSM state type and ratio range check for the downsampler rate controller.
package downsampler_pkg;

    localparam logic [31:0] ONE_VALUE        = 32'h8000_0000;  // 1.0 in ufix_32_31
    localparam logic [31:0] INV_ONE          = 32'h0040_0000;  // 1.0 in ufix_32_22
    localparam logic [31:0] MIN_RATIO_EXCL   = 32'h0020_0000;
    localparam int unsigned DIV_DIVIDEND_EXP = 53;
    localparam int unsigned DIV_STEPS        = 32;

    // Upper dividend bits (2^53 >> 32) preloaded; every valid divisor exceeds them,
    // so the 22 leading quotient bits are known zero and only 32 steps remain.
    localparam logic [32:0] DIV_REM_INIT = 33'(1) << (DIV_DIVIDEND_EXP - DIV_STEPS);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_IDLE,
        ST_CHECK,
        ST_DIVIDE,
        ST_APPLY
    } ds_state_t;

    function automatic logic ratio_in_range(input logic [31:0] ratio);
        return (ratio > MIN_RATIO_EXCL) && (ratio <= ONE_VALUE);
    endfunction

endpackage

// File: rtl/ratio_inv_divider.sv
// Iterative restoring divider producing floor(2^53 / divisor), one quotient bit per cycle.
module ratio_inv_divider
    import downsampler_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient
);

    logic [32:0] rem_q;
    logic [31:0] div_q;
    logic [30:0] quo_q;
    logic [4:0]  step_q;
    logic        run_q;

    logic [32:0] rem_shift;
    logic [32:0] rem_sub;
    logic        q_bit;

    // Remaining dividend bits are all zero, so each step just shifts a zero in.
    always_comb begin
        rem_shift = rem_q << 1;
        rem_sub   = rem_shift - {1'b0, div_q};
        q_bit     = ~rem_sub[32];
    end

    // done marks the cycle whose step yields the final bit; quotient is valid then.
    assign done     = run_q && (step_q == 5'(DIV_STEPS - 1));
    assign quotient = {quo_q, q_bit};

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rem_q  <= '0;
            div_q  <= '0;
            quo_q  <= '0;
            step_q <= '0;
            run_q  <= 1'b0;
        end else if (start) begin
            rem_q  <= DIV_REM_INIT;
            div_q  <= divisor;
            quo_q  <= '0;
            step_q <= '0;
            run_q  <= 1'b1;
        end else if (run_q) begin
            rem_q  <= q_bit ? rem_sub : rem_shift;
            quo_q  <= {quo_q[29:0], q_bit};
            step_q <= step_q + 5'd1;
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/downsampler_rate_ctrl.sv
// Accepts decimation-ratio requests, validates them, computes the inverse and
// applies both to the downsampler core behind a timed core reset.
module downsampler_rate_ctrl
    import downsampler_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] cfg_ratio,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    output logic        cfg_error,
    output logic [31:0] freqRatio,
    output logic [31:0] freqRatioInv,
    output logic        core_aresetn,
    output logic        busy
);

    localparam logic [7:0] CNT_LAST = 8'(RESET_CYCLES - 1);

    ds_state_t   state_q;
    logic [7:0]  cnt_q;
    logic [31:0] ratio_q;
    logic        ratio_ok;
    logic        div_start;
    logic        div_done;
    logic [31:0] div_quot;

    assign ratio_ok  = ratio_in_range(ratio_q);
    assign div_start = (state_q == ST_CHECK) && ratio_ok;

    ratio_inv_divider u_divider (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .start    (div_start),
        .divisor  (ratio_q),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            ratio_q      <= ONE_VALUE;
            freqRatio    <= ONE_VALUE;
            freqRatioInv <= INV_ONE;
            core_aresetn <= 1'b0;
            cfg_ready    <= 1'b0;
            cfg_error    <= 1'b0;
            busy         <= 1'b1;
        end else begin
            case (state_q)
                // HOLD and APPLY share the timed core-reset release.
                ST_HOLD, ST_APPLY: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q      <= ST_IDLE;
                        cnt_q        <= '0;
                        core_aresetn <= 1'b1;
                        cfg_ready    <= 1'b1;
                        busy         <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        ratio_q   <= cfg_ratio;
                        cfg_error <= 1'b0;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b1;
                        state_q   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (ratio_ok) begin
                        state_q <= ST_DIVIDE;
                    end else begin
                        state_q   <= ST_IDLE;
                        cfg_error <= 1'b1;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                ST_DIVIDE: begin
                    if (div_done) begin
                        freqRatio    <= ratio_q;
                        freqRatioInv <= div_quot;
                        core_aresetn <= 1'b0;
                        cnt_q        <= '0;
                        state_q      <= ST_APPLY;
                    end
                end
                default: begin
                    state_q <= ST_HOLD;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_downsampler_rate_ctrl.sv
// Directed-vector bench for downsampler_rate_ctrl: request table plus hold and abort sequences.
module tb_downsampler_rate_ctrl;

    localparam int unsigned    RST_CYC  = 4;
    localparam logic [31:0]    DEF_R    = 32'h8000_0000;
    localparam logic [31:0]    DEF_I    = 32'h0040_0000;
    localparam int             NVEC     = 10;

    logic        aclk;
    logic        aresetn;
    logic [31:0] cfg_ratio;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_error;
    logic [31:0] freqRatio;
    logic [31:0] freqRatioInv;
    logic        core_aresetn;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] cur_r;
    logic [31:0] cur_i;

    typedef struct {
        logic [31:0] ratio;
        logic        bad;
        logic [31:0] inv;
    } vec_t;

    vec_t vecs[NVEC];

    downsampler_rate_ctrl #(.RESET_CYCLES(RST_CYC)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .cfg_ratio    (cfg_ratio),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_error    (cfg_error),
        .freqRatio    (freqRatio),
        .freqRatioInv (freqRatioInv),
        .core_aresetn (core_aresetn),
        .busy         (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_defaults(input string tag);
        chk({tag, " freqRatio"}, freqRatio, DEF_R);
        chk({tag, " freqRatioInv"}, freqRatioInv, DEF_I);
    endtask

    // Releases aresetn and counts the cycles core_aresetn stays low afterwards.
    task automatic release_reset(input string tag);
        int n;
        n = 0;
        aresetn = 1'b1;
        for (int j = 0; j < 20; j++) begin
            if (core_aresetn !== 1'b0) break;
            n++;
            tick();
        end
        chk({tag, " hold_cycles"}, n, RST_CYC);
        chk({tag, " cfg_ready"}, cfg_ready, 1'b1);
        chk({tag, " busy"}, busy, 1'b0);
        chk_defaults(tag);
    endtask

    task automatic send(input logic [31:0] r, input bit hold, input logic [31:0] next_r);
        int w;
        w = 0;
        while (cfg_ready !== 1'b1 && w < 100) begin
            tick();
            w++;
        end
        if (w >= 100) chk("ready_timeout", cfg_ready, 1'b1);
        cfg_ratio = r;
        cfg_valid = 1'b1;
        tick();
        if (hold) cfg_ratio = next_r;
        else      cfg_valid = 1'b0;
    endtask

    // Called on cycle 1 after an accept; follows the request until cfg_ready returns.
    task automatic observe(input bit bad, input logic [31:0] new_r, input logic [31:0] new_i,
                           input string tag);
        int first_low, low_n, ready_at;
        bit glitch;
        first_low = 0;
        low_n     = 0;
        ready_at  = 0;
        glitch    = 1'b0;
        chk({tag, " err_clear"}, cfg_error, 1'b0);
        chk({tag, " busy"}, busy, 1'b1);
        for (int k = 1; k <= 60; k++) begin
            if (core_aresetn === 1'b0) begin
                low_n++;
                if (first_low == 0) first_low = k;
            end else if (first_low == 0) begin
                if (freqRatio !== cur_r || freqRatioInv !== cur_i) glitch = 1'b1;
            end else begin
                if (freqRatio !== new_r || freqRatioInv !== new_i) glitch = 1'b1;
            end
            if (cfg_ready === 1'b1) begin
                ready_at = k;
                break;
            end
            tick();
        end
        chk({tag, " stable_outputs"}, glitch, 1'b0);
        if (bad) begin
            chk({tag, " ready_cycle"}, ready_at, 2);
            chk({tag, " core_low_cycles"}, low_n, 0);
            chk({tag, " cfg_error"}, cfg_error, 1'b1);
            chk({tag, " freqRatio"}, freqRatio, cur_r);
            chk({tag, " freqRatioInv"}, freqRatioInv, cur_i);
        end else begin
            chk({tag, " ready_cycle"}, ready_at, 38);
            chk({tag, " apply_cycle"}, first_low, 34);
            chk({tag, " core_low_cycles"}, low_n, RST_CYC);
            chk({tag, " cfg_error"}, cfg_error, 1'b0);
            chk({tag, " freqRatio"}, freqRatio, new_r);
            chk({tag, " freqRatioInv"}, freqRatioInv, new_i);
            cur_r = new_r;
            cur_i = new_i;
        end
    endtask

    initial begin
        bit moved;

        vecs[0] = '{32'h4000_0000, 1'b0, 32'h0080_0000};
        vecs[1] = '{32'h2AAA_AAAB, 1'b0, 32'h00BF_FFFF};
        vecs[2] = '{32'h8000_0000, 1'b0, 32'h0040_0000};
        vecs[3] = '{32'h0020_0000, 1'b1, 32'h0000_0000};
        vecs[4] = '{32'h8000_0001, 1'b1, 32'h0000_0000};
        vecs[5] = '{32'h0020_0001, 1'b0, 32'hFFFF_F800};
        vecs[6] = '{32'h6000_0000, 1'b0, 32'h0055_5555};
        vecs[7] = '{32'h6000_0000, 1'b0, 32'h0055_5555};
        vecs[8] = '{32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[9] = '{32'hFFFF_FFFF, 1'b1, 32'h0000_0000};

        aresetn   = 1'b0;
        cfg_valid = 1'b0;
        cfg_ratio = '0;
        cur_r     = DEF_R;
        cur_i     = DEF_I;

        repeat (3) tick();
        chk_defaults("reset");
        chk("reset core_aresetn", core_aresetn, 1'b0);
        chk("reset cfg_ready", cfg_ready, 1'b0);
        chk("reset cfg_error", cfg_error, 1'b0);
        chk("reset busy", busy, 1'b1);
        release_reset("post_reset");

        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i].ratio, 1'b0, '0);
            observe(vecs[i].bad, vecs[i].ratio, vecs[i].inv, $sformatf("vec%0d", i));
        end

        // Second ratio held on cfg_valid throughout the first request.
        send(32'h4000_0000, 1'b1, 32'h2000_0000);
        observe(1'b0, 32'h4000_0000, 32'h0080_0000, "hold_a");
        send(32'h2000_0000, 1'b0, '0);
        observe(1'b0, 32'h2000_0000, 32'h0100_0000, "hold_b");

        // Reset asserted in the middle of DIVIDE.
        send(32'h1000_0000, 1'b0, '0);
        repeat (10) tick();
        aresetn = 1'b0;
        repeat (2) tick();
        chk_defaults("abort");
        chk("abort core_aresetn", core_aresetn, 1'b0);
        chk("abort cfg_ready", cfg_ready, 1'b0);
        chk("abort busy", busy, 1'b1);
        cur_r = DEF_R;
        cur_i = DEF_I;
        release_reset("abort_release");
        moved = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (freqRatio !== DEF_R || freqRatioInv !== DEF_I || core_aresetn !== 1'b1) moved = 1'b1;
            tick();
        end
        chk("abort never_applied", moved, 1'b0);

        send(32'h4000_0000, 1'b0, '0);
        observe(1'b0, 32'h4000_0000, 32'h0080_0000, "recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
